// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- 8N1 UART byte receiver, LSB first, one sample at mid-bit.
//
// Turns the raw asynchronous rx pin into a one-cycle rx_valid strobe plus a
// held rx_data byte for the downstream command logic. The pin is brought into
// the clk domain with a two-flop synchronizer. Every decision uses only the
// synchronized copy, rx_s.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial input, idle high
//   rx_valid   out  one-cycle pulse: rx_data holds a new good byte
//   rx_data    out  last good byte, held until the next good byte
//   frame_err  out  one-cycle pulse: stop bit sampled low, byte dropped
//   rx_busy    out  high while a frame is in progress
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Synchronizer flops. They preset to 1 so reset looks like an idle line.
  logic          sync1_reg, sync2_reg;
  logic          rx_s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          ferr_reg, ferr_next;
  logic          busy_reg;

  assign rx_s = sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      // Wait to mid start bit and confirm the line is still low. A line that
      // is high again here was only a glitch.
      START: begin
        if (cnt_reg == HALF) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // START ends at mid start bit. Each full bit period from that point
      // therefore lands at mid data bit.
      DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // The frame closes at mid stop bit. This leaves half a bit to catch a
      // start bit that follows with no idle gap.
      STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // Hold off until the line returns high. A break condition then
      // produces no spurious bytes.
      BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      // busy_reg is driven from the next state so that it tracks
      // (state != IDLE) on the same cycle as the state register.
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign rx_valid  = valid_reg;
  assign rx_data   = data_reg;
  assign frame_err = ferr_reg;
  assign rx_busy   = busy_reg;

endmodule
